vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates raster timing for the VGA pixel path: horizontal and vertical pixel counters, a visible-area flag, and sync pulses.
- Sits directly upstream of the pixel-colour stages. Its hpos/vpos/visible outputs drive their i_hpos/i_vpos/i_visible inputs; its syncs go to the board VGA connector.
- Default timing is 640x480@60 Hz from a 25 MHz pixel clock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of o_hsync (0 = active-low)
VSYNC_POL, 0, active level of o_vsync (0 = active-low)

Ports:
i_clk  input  1  pixel clock
i_rst_n  input  1  asynchronous active-low reset
o_hpos  output  10  current pixel column, 0..H_TOTAL-1
o_vpos  output  10  current line, 0..V_TOTAL-1
o_visible  output  1  high when hpos<H_ACTIVE and vpos<V_ACTIVE
o_hsync  output  1  horizontal sync, polarity per HSYNC_POL
o_vsync  output  1  vertical sync, polarity per VSYNC_POL
o_line_start  output  1  one-cycle pulse when hpos==0
o_frame_start  output  1  one-cycle pulse when hpos==0 and vpos==0
o_frame_cnt  output  8  frame counter, wraps 255->0

Behaviour:
- Derived values: H_TOTAL = sum of the H_* parameters (800 by default); V_TOTAL = sum of the V_* parameters (525 by default). All outputs are registered.
- Reset (i_rst_n low, asynchronous, takes effect immediately):
  - hpos=0, vpos=0, frame_cnt=0
  - visible=0, line_start=0, frame_start=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL (inactive levels)
  - An internal run flag is cleared.
- Startup: first rising edge after reset release sets the run flag and presents position (0,0), with visible=1, line_start=1, frame_start=1, frame_cnt=0. Hpos/vpos do not advance on this edge.
- Running, each edge:
  - hpos increments.
  - At hpos==H_TOTAL-1, hpos wraps to 0 and vpos increments.
  - At hpos==H_TOTAL-1 and vpos==V_TOTAL-1, both wrap to 0 and frame_cnt increments (8-bit modulo).
- Alignment: all decoded outputs describe the same position as the o_hpos/o_vpos presented in that cycle. Decode from next-state counters; no skew between outputs.
- hsync is active while H_ACTIVE+H_FRONT <= hpos < H_ACTIVE+H_FRONT+H_SYNC (656..751 by default).
- vsync is active while V_ACTIVE+V_FRONT <= vpos < V_ACTIVE+V_FRONT+V_SYNC (490..491 by default). It spans whole lines, changing at hpos==0.
- line_start is high exactly one cycle per line. frame_start is high exactly one cycle per frame, coincident with one line_start.
- frame_cnt changes in the same cycle frame_start asserts, so (0,0) shows the new count.
- Counter width: 10 bits covers H_TOTAL, V_TOTAL <= 1024. Larger totals are unsupported; an elaboration-time check flags them.
- Reset mid-frame: immediate return to reset values. The next frame restarts from the startup sequence. No partial sync pulse remains asserted.
- No input handshake: the pixel stage samples outputs combinationally in the same cycle.

Test Plan:
- Reset then release, defaults -> first edge: hpos=0, vpos=0, visible=1, line_start=1, frame_start=1, hsync=vsync=1. Next edge: hpos=1, line_start=0.
- Run one line -> visible is 1 for hpos 0..639 and 0 for 640..799. hsync is 0 exactly for hpos 656..751 (96 cycles). After hpos=799 comes hpos=0, vpos=1, line_start=1.
- Run full frame -> vsync is 0 for vpos 490..491 (1600 cycles). After (799,524) comes (0,0) with frame_start=1 and frame_cnt=1. Next frame_start arrives exactly 420000 cycles later.
- Small params (H 4/1/1/1, V 3/1/1/1, HSYNC_POL=1) for 256+ frames -> H_TOTAL=7, V_TOTAL=6, 42 cycles/frame. hsync high only at hpos=5. frame_cnt goes 255->0.
- Assert i_rst_n low at (300,200) asynchronously, mid-cycle -> outputs immediately hpos=0, vpos=0, visible=0, syncs inactive. Release -> startup sequence repeats, frame_cnt=0.
- Every cycle, continuous check -> visible, hsync, vsync, line_start and frame_start match the decode of the presented hpos/vpos. Zero mismatches over 3 default frames.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Raster timing generator for the VGA pixel path. Produces
//                the pixel column/line counters, a visible-area flag,
//                horizontal/vertical sync pulses, line/frame start strobes
//                and an 8-bit frame counter. All outputs are registered and
//                decoded from the next-state counters, so every output in a
//                given cycle describes the same (hpos, vpos) position.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk          in   1   pixel clock
//    i_rst_n        in   1   asynchronous active-low reset
//    o_hpos         out  10  current pixel column, 0..H_TOTAL-1
//    o_vpos         out  10  current line, 0..V_TOTAL-1
//    o_visible      out  1   high inside the active area
//    o_hsync        out  1   horizontal sync, active level HSYNC_POL
//    o_vsync        out  1   vertical sync, active level VSYNC_POL
//    o_line_start   out  1   one-cycle strobe at hpos==0
//    o_frame_start  out  1   one-cycle strobe at hpos==0, vpos==0
//    o_frame_cnt    out  8   frame counter, wraps 255->0
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos,
    output logic       o_visible,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic [7:0] o_frame_cnt
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] c_H_LAST = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST = 10'(c_V_TOTAL - 1);

    // Decode bounds are held at 11 bits so an end bound of exactly 1024
    // does not alias to zero.
    localparam logic [10:0] c_H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_VIS_END  = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_START   = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] c_HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] c_VS_START   = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] c_VS_END     = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic c_HS_ACT = 1'(HSYNC_POL);
    localparam logic c_VS_ACT = 1'(VSYNC_POL);

    // 10-bit counters cannot represent totals above 1024.
    generate
        if (c_H_TOTAL > 1024 || c_V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       run_q,         run_d;
    logic [9:0] hpos_q,        hpos_d;
    logic [9:0] vpos_q,        vpos_d;
    logic [7:0] frame_cnt_q,   frame_cnt_d;
    logic       visible_q,     visible_d;
    logic       hsync_q,       hsync_d;
    logic       vsync_q,       vsync_d;
    logic       line_start_q,  line_start_d;
    logic       frame_start_q, frame_start_d;

    // ------------------------------------------------------------------
    // Next-state counters. The first edge after reset only arms the run
    // flag and presents (0,0); counting begins on the following edge.
    // ------------------------------------------------------------------
    always_comb begin
        run_d       = 1'b1;
        hpos_d      = hpos_q;
        vpos_d      = vpos_q;
        frame_cnt_d = frame_cnt_q;
        if (!run_q) begin
            hpos_d = 10'd0;
            vpos_d = 10'd0;
        end else if (hpos_q == c_H_LAST) begin
            hpos_d = 10'd0;
            if (vpos_q == c_V_LAST) begin
                vpos_d      = 10'd0;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                vpos_d = vpos_q + 10'd1;
            end
        end else begin
            hpos_d = hpos_q + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode from the next-state position, so the registered
    // flags line up with the registered counters.
    // ------------------------------------------------------------------
    always_comb begin
        visible_d     = ({1'b0, hpos_d} < c_H_VIS_END) &&
                        ({1'b0, vpos_d} < c_V_VIS_END);
        hsync_d       = (({1'b0, hpos_d} >= c_HS_START) &&
                         ({1'b0, hpos_d} <  c_HS_END)) ? c_HS_ACT : ~c_HS_ACT;
        vsync_d       = (({1'b0, vpos_d} >= c_VS_START) &&
                         ({1'b0, vpos_d} <  c_VS_END)) ? c_VS_ACT : ~c_VS_ACT;
        // hpos_d is zero only at startup or on a line wrap.
        line_start_d  = (hpos_d == 10'd0);
        frame_start_d = (hpos_d == 10'd0) && (vpos_d == 10'd0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q         <= 1'b0;
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            frame_cnt_q   <= 8'd0;
            visible_q     <= 1'b0;
            hsync_q       <= ~c_HS_ACT;
            vsync_q       <= ~c_VS_ACT;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            run_q         <= run_d;
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_cnt_q   <= frame_cnt_d;
            visible_q     <= visible_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_hpos        = hpos_q;
    assign o_vpos        = vpos_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_visible     = visible_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule
`default_nettype wire
